// File: rtl/cofi_ctrl.sv
// Frame-synchronous enable controller for the composite-blend filter.
// Measures active line width per frame and switches the filter only at frame end.
module cofi_ctrl #(
    parameter int WIDTH_BITS     = 11,
    parameter int AUTO_MIN_WIDTH = 384,
    parameter int CONFIRM_FRAMES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pix_ce,
    input  logic                  hblank,
    input  logic                  vblank,
    input  logic [1:0]            mode,
    output logic                  cofi_enable,
    output logic [WIDTH_BITS-1:0] active_width,
    output logic                  width_valid,
    output logic                  switch_pending
);

    localparam logic [0:0] ST_STEADY  = 1'b0;
    localparam logic [0:0] ST_CONFIRM = 1'b1;

    localparam logic [1:0] MODE_ON   = 2'b01;
    localparam logic [1:0] MODE_AUTO = 2'b10;

    localparam logic [WIDTH_BITS-1:0] PX_MAX = '1;
    localparam logic [WIDTH_BITS-1:0] MIN_W  = WIDTH_BITS'(AUTO_MIN_WIDTH);
    localparam logic [3:0]            CONF_N = 4'(CONFIRM_FRAMES);

    logic                  hb_q;
    logic                  vb_q;
    logic [WIDTH_BITS-1:0] px_cnt;
    logic [WIDTH_BITS-1:0] line_w;
    logic                  same_w;
    logic                  line_seen;
    logic [0:0]            state;
    logic [3:0]            conf_cnt;

    logic                  h_rise;
    logic                  v_rise;
    logic                  line_end;
    logic                  line_ok;
    logic                  first_line;
    logic                  eff_seen;
    logic [WIDTH_BITS-1:0] eff_w;
    logic                  eff_same;
    logic                  frame_valid;
    logic                  auto_mode;
    logic                  frame_target;
    logic                  now_target;
    logic [3:0]            conf_next;

    function automatic logic target_of(
        input logic [1:0]            m,
        input logic                  valid,
        input logic [WIDTH_BITS-1:0] w,
        input logic                  en
    );
        logic t;
        unique case (m)
            MODE_ON:   t = 1'b1;
            MODE_AUTO: t = valid ? (w >= MIN_W) : en;
            default:   t = 1'b0;
        endcase
        return t;
    endfunction

    // A line ends only while the previous sample was still in active video, so a
    // line ending on the same pix_ce as the vblank rise still counts for the frame.
    assign h_rise     = pix_ce && hblank && !hb_q;
    assign v_rise     = pix_ce && vblank && !vb_q;
    assign line_end   = h_rise && !vb_q;
    assign line_ok    = line_end && (px_cnt != '0);
    assign first_line = line_ok && !line_seen;

    assign eff_seen    = line_seen || line_ok;
    assign eff_w       = first_line ? px_cnt : line_w;
    assign eff_same    = same_w && !(line_ok && line_seen && (px_cnt != line_w));
    assign frame_valid = eff_seen && eff_same;

    assign auto_mode    = (mode == MODE_AUTO);
    assign frame_target = target_of(mode, frame_valid, eff_w, cofi_enable);
    assign now_target   = target_of(mode, width_valid, active_width, cofi_enable);
    assign conf_next    = (state == ST_CONFIRM) ? conf_cnt + 4'd1 : 4'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hb_q      <= 1'b1;
            vb_q      <= 1'b1;
            px_cnt    <= '0;
            line_w    <= '0;
            same_w    <= 1'b1;
            line_seen <= 1'b0;
        end else if (pix_ce) begin
            hb_q <= hblank;
            vb_q <= vblank;
            if (v_rise) begin
                px_cnt    <= '0;
                same_w    <= 1'b1;
                line_seen <= 1'b0;
            end else if (line_end) begin
                px_cnt <= '0;
                if (first_line) begin
                    line_w    <= px_cnt;
                    line_seen <= 1'b1;
                end else if (line_ok && (px_cnt != line_w)) begin
                    same_w <= 1'b0;
                end
            end else if (!hblank && !vblank && (px_cnt != PX_MAX)) begin
                px_cnt <= px_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cofi_enable    <= 1'b0;
            active_width   <= '0;
            width_valid    <= 1'b0;
            switch_pending <= 1'b0;
            state          <= ST_STEADY;
            conf_cnt       <= '0;
        end else begin
            switch_pending <= (now_target != cofi_enable);
            if (v_rise) begin
                if (eff_seen) begin
                    active_width <= eff_w;
                end
                width_valid <= frame_valid;
                if (frame_target == cofi_enable) begin
                    state    <= ST_STEADY;
                    conf_cnt <= '0;
                end else if (!auto_mode || (conf_next >= CONF_N)) begin
                    cofi_enable <= frame_target;
                    state       <= ST_STEADY;
                    conf_cnt    <= '0;
                end else begin
                    state    <= ST_CONFIRM;
                    conf_cnt <= conf_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_cofi_ctrl.sv
// Bench for cofi_ctrl: a per-pixel behavioural model (line width queue, streak
// count) checked against the DUT on every clock, plus literal checkpoints.
module tb_cofi_ctrl;

    localparam int WB   = 11;
    localparam int MINW = 384;
    localparam int CONF = 2;
    localparam int SATV = 2047;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          pix_ce = 1'b0;
    logic          hblank = 1'b1;
    logic          vblank = 1'b1;
    logic [1:0]    mode = 2'b00;
    logic          cofi_enable;
    logic [WB-1:0] active_width;
    logic          width_valid;
    logic          switch_pending;

    cofi_ctrl #(
        .WIDTH_BITS(WB),
        .AUTO_MIN_WIDTH(MINW),
        .CONFIRM_FRAMES(CONF)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pix_ce(pix_ce),
        .hblank(hblank),
        .vblank(vblank),
        .mode(mode),
        .cofi_enable(cofi_enable),
        .active_width(active_width),
        .width_valid(width_valid),
        .switch_pending(switch_pending)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    bit gaps = 0;

    bit m_hp, m_vp, m_en, m_wv, m_pend;
    int m_cnt, m_aw, m_streak;
    int m_lines[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit want(input int md, input bit v, input int w, input bit en);
        if (md == 1) return 1'b1;
        if (md == 2) return v ? (w >= MINW) : en;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_hp = 1; m_vp = 1; m_en = 0; m_wv = 0; m_pend = 0;
        m_cnt = 0; m_aw = 0; m_streak = 0;
        m_lines.delete();
    endtask

    task automatic frame_done(input int md);
        bit valid;
        bit t;
        valid = (m_lines.size() > 0);
        foreach (m_lines[i]) if (m_lines[i] != m_lines[0]) valid = 0;
        if (m_lines.size() > 0) m_aw = m_lines[0];
        m_wv = valid;
        t = want(md, valid, m_aw, m_en);
        if (md != 2) begin
            m_en = t;
            m_streak = 0;
        end else if (t == m_en) begin
            m_streak = 0;
        end else begin
            m_streak++;
            if (m_streak >= CONF) begin
                m_en = t;
                m_streak = 0;
            end
        end
        m_lines.delete();
        m_cnt = 0;
    endtask

    task automatic model_step(input bit ce, input bit h, input bit v, input int md);
        m_pend = (want(md, m_wv, m_aw, m_en) != m_en);
        if (ce) begin
            if (!h && !v) m_cnt = (m_cnt < SATV) ? m_cnt + 1 : SATV;
            if (h && !m_hp && !m_vp) begin
                if (m_cnt > 0) m_lines.push_back(m_cnt);
                m_cnt = 0;
            end
            if (v && !m_vp) frame_done(md);
            m_hp = h;
            m_vp = v;
        end
    endtask

    task automatic compare();
        chk("cofi_enable", int'(cofi_enable), int'(m_en));
        chk("active_width", int'(active_width), m_aw);
        chk("width_valid", int'(width_valid), int'(m_wv));
        chk("switch_pending", int'(switch_pending), int'(m_pend));
    endtask

    task automatic cyc(input bit ce, input bit h, input bit v);
        pix_ce = ce;
        hblank = h;
        vblank = v;
        model_step(ce, h, v, int'(mode));
        @(negedge clk);
        compare();
    endtask

    task automatic px(input bit h, input bit v);
        if (gaps) while ($urandom_range(0, 3) == 0) cyc(1'b0, h, v);
        cyc(1'b1, h, v);
    endtask

    task automatic active(input int n);
        repeat (n) px(1'b0, 1'b0);
    endtask

    task automatic hb(input int n);
        repeat (n) px(1'b1, 1'b0);
    endtask

    task automatic vb(input int n);
        repeat (n) px(1'b1, 1'b1);
    endtask

    task automatic frame(input int n, input int w, input int wlast, input bit simul);
        for (int i = 0; i < n; i++) begin
            active((i == n - 1) ? wlast : w);
            if (!(i == n - 1 && simul)) hb(3);
        end
        vb(4);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_enable", int'(cofi_enable), 0);
        chk("rst_width", int'(active_width), 0);
        chk("rst_valid", int'(width_valid), 0);
        chk("rst_pending", int'(switch_pending), 0);
        model_reset();
        @(negedge clk);
        compare();
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        compare();
        reset = 1'b0;

        // forced on: enable follows the first frame end
        mode = 2'b01;
        hb(2);
        chk("t1_pend_before", int'(switch_pending), 1);
        frame(2, 256, 256, 0);
        chk("t1_enable", int'(cofi_enable), 1);
        chk("t1_pend_after", int'(switch_pending), 0);
        frame(2, 256, 256, 0);

        // auto with confirmation
        mode = 2'b00;
        frame(2, 512, 512, 0);
        chk("t2_off", int'(cofi_enable), 0);
        mode = 2'b10;
        frame(2, 512, 512, 1);
        chk("t2_width", int'(active_width), 512);
        chk("t2_valid", int'(width_valid), 1);
        chk("t2_enable_f1", int'(cofi_enable), 0);
        frame(2, 512, 512, 0);
        chk("t2_enable_f2", int'(cofi_enable), 1);

        frame(2, 256, 256, 0);
        chk("t3_glitch", int'(cofi_enable), 1);
        frame(2, 512, 512, 0);
        frame(2, 256, 256, 0);
        frame(2, 256, 256, 1);
        chk("t3_off", int'(cofi_enable), 0);
        frame(2, 512, 512, 0);
        frame(2, 512, 512, 0);
        chk("t3_on", int'(cofi_enable), 1);

        frame(2, 320, 321, 0);
        chk("t4_valid", int'(width_valid), 0);
        chk("t4_enable", int'(cofi_enable), 1);

        // mode change mid-frame waits for frame end
        mode = 2'b01;
        frame(1, 512, 512, 0);
        active(100);
        mode = 2'b00;
        hb(1);
        chk("t5_mid", int'(cofi_enable), 1);
        active(150);
        hb(3);
        vb(4);
        chk("t5_end", int'(cofi_enable), 0);

        // reset mid-line, then saturation
        mode = 2'b01;
        frame(1, 300, 300, 0);
        active(50);
        do_reset();
        active(250);
        hb(3);
        active(300);
        hb(3);
        vb(4);
        chk("t6_first_valid", int'(width_valid), 0);
        frame(2, 300, 300, 0);
        chk("t6_width", int'(active_width), 300);
        chk("t6_valid", int'(width_valid), 1);
        frame(1, 2100, 2100, 0);
        chk("t6_sat", int'(active_width), 2047);

        // randomized frames with pixel-enable gaps
        gaps = 1;
        for (int f = 0; f < 16; f++) begin
            int w;
            int wl;
            mode = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'($urandom_range(0, 3));
            w = ($urandom_range(0, 2) == 0) ? MINW - 1 + $urandom_range(0, 1)
                                            : $urandom_range(200, 600);
            wl = ($urandom_range(0, 3) == 0) ? w + 1 : w;
            frame($urandom_range(1, 2), w, wl, 1'($urandom_range(0, 1)));
        end
        gaps = 0;
        repeat (20) cyc(1'b0, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
